rgmii_rx_frame_buffer: RTL and testbench

Store-and-forward receive buffer placed directly downstream of the RGMII MAC receive AXI-Stream output, in the rx_clk domain. It accepts bytes with no backpressure and filters each frame on destination MAC address, runt length, the MAC error flag (tuser) and buffer overflow. It commits only good frames to a circular byte RAM. Committed frames are replayed on a backpressured AXI-Stream master toward the host DMA/registers.

---
 rtl/rgmii_rx_frame_buffer.sv | 243 ++++++++++++++++++++++++
 tb/tb_rgmii_rx_frame_buffer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_rx_frame_buffer.sv
// Store-and-forward receive buffer behind the RGMII MAC: filters frames on DA, runt length,
// MAC error and space, commits good frames to a circular RAM and replays them on AXI-Stream.
module rgmii_rx_frame_buffer #(
    parameter int ADDR_WIDTH = 11,
    parameter int MIN_LEN    = 14,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_int,
    input  logic                 rst_int_n,
    input  logic [7:0]           rx_axis_tdata,
    input  logic                 rx_axis_tvalid,
    input  logic                 rx_axis_tlast,
    input  logic                 rx_axis_tuser,
    input  logic [47:0]          mac_addr,
    input  logic                 promisc,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [CNT_WIDTH-1:0] frames_ok,
    output logic [CNT_WIDTH-1:0] frames_drop,
    output logic                 overflow,
    output logic                 buffer_empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [16:0]           MIN_LEN_W = 17'(MIN_LEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic [8:0]            mem [0:DEPTH-1];

    logic [1:0]            state_r, state_n;
    logic [ADDR_WIDTH-1:0] wr_ptr_r, wr_ptr_n;
    logic [ADDR_WIDTH-1:0] commit_ptr_r, commit_ptr_n;
    logic [ADDR_WIDTH-1:0] rd_ptr_r, rd_ptr_n;
    logic [15:0]           byte_cnt_r, byte_cnt_n;
    logic                  match_uc_r, match_uc_n;
    logic                  match_bc_r, match_bc_n;
    logic [CNT_WIDTH-1:0]  frames_ok_r, frames_drop_r;
    logic                  overflow_r;
    logic                  tvalid_r, tvalid_n;
    logic                  tlast_r;
    logic [7:0]            tdata_r;
    logic                  empty_r, empty_n;

    logic                  full_s;
    logic                  ram_we_s;
    logic                  ok_inc_s, drop_inc_s, ovf_s;
    logic [2:0]            hdr_idx_s;
    logic [7:0]            mac_byte_s;
    logic                  uc_hit_s, bc_hit_s;
    logic [15:0]           cnt_inc_s;
    logic [16:0]           len_s;
    logic                  len_ok_s;
    logic                  hs_s, load_s;
    logic [ADDR_WIDTH-1:0] fetch_addr_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    // The slot at rd_ptr is still owned by the output register, hence the +1 full test.
    assign full_s    = ((wr_ptr_r + PTR_ONE) == rd_ptr_r);
    assign hdr_idx_s = (state_r == ST_IDLE) ? 3'd0 : byte_cnt_r[2:0];
    assign uc_hit_s  = (rx_axis_tdata == mac_byte_s);
    assign bc_hit_s  = (rx_axis_tdata == 8'hFF);
    assign cnt_inc_s = (&byte_cnt_r) ? byte_cnt_r : (byte_cnt_r + 16'd1);
    assign len_s     = {1'b0, byte_cnt_r} + 17'd1;
    assign len_ok_s  = (len_s >= MIN_LEN_W);

    // Station address byte expected at the current header position.
    always_comb begin
        case (hdr_idx_s)
            3'd0:    mac_byte_s = mac_addr[47:40];
            3'd1:    mac_byte_s = mac_addr[39:32];
            3'd2:    mac_byte_s = mac_addr[31:24];
            3'd3:    mac_byte_s = mac_addr[23:16];
            3'd4:    mac_byte_s = mac_addr[15:8];
            3'd5:    mac_byte_s = mac_addr[7:0];
            default: mac_byte_s = 8'h00;
        endcase
    end

    // Write-side FSM: header filtering, space check, commit or rewind.
    always_comb begin
        state_n      = state_r;
        wr_ptr_n     = wr_ptr_r;
        commit_ptr_n = commit_ptr_r;
        byte_cnt_n   = byte_cnt_r;
        match_uc_n   = match_uc_r;
        match_bc_n   = match_bc_r;
        ram_we_s     = 1'b0;
        ok_inc_s     = 1'b0;
        drop_inc_s   = 1'b0;
        ovf_s        = 1'b0;
        if (rx_axis_tvalid) begin
            case (state_r)
                ST_IDLE, ST_HDR, ST_BODY: begin
                    if (full_s) begin
                        wr_ptr_n   = commit_ptr_r;
                        ovf_s      = 1'b1;
                        drop_inc_s = 1'b1;
                        state_n    = rx_axis_tlast ? ST_IDLE : ST_DROP;
                    end else begin
                        ram_we_s = 1'b1;
                        wr_ptr_n = wr_ptr_r + PTR_ONE;
                        if (state_r == ST_IDLE) begin
                            byte_cnt_n = 16'd1;
                            match_uc_n = uc_hit_s;
                            match_bc_n = bc_hit_s;
                        end else if (state_r == ST_HDR) begin
                            byte_cnt_n = cnt_inc_s;
                            match_uc_n = match_uc_r & uc_hit_s;
                            match_bc_n = match_bc_r & bc_hit_s;
                        end else begin
                            byte_cnt_n = cnt_inc_s;
                            match_uc_n = match_uc_r;
                            match_bc_n = match_bc_r;
                        end
                        // Only BODY implies the address filter already passed.
                        if (rx_axis_tlast) begin
                            state_n = ST_IDLE;
                            if ((state_r == ST_BODY) && !rx_axis_tuser && len_ok_s) begin
                                commit_ptr_n = wr_ptr_r + PTR_ONE;
                                ok_inc_s     = 1'b1;
                            end else begin
                                wr_ptr_n   = commit_ptr_r;
                                drop_inc_s = 1'b1;
                            end
                        end else if (state_r == ST_IDLE) begin
                            state_n = ST_HDR;
                        end else if ((state_r == ST_HDR) && (byte_cnt_r == 16'd5)) begin
                            if (promisc || match_uc_n || match_bc_n) begin
                                state_n = ST_BODY;
                            end else begin
                                state_n    = ST_DROP;
                                wr_ptr_n   = commit_ptr_r;
                                drop_inc_s = 1'b1;
                            end
                        end else begin
                            state_n = state_r;
                        end
                    end
                end
                ST_DROP: begin
                    if (rx_axis_tlast) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_DROP;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Read side: the registered RAM read is the output register; it refills in the handshake cycle.
    always_comb begin
        hs_s = tvalid_r & m_axis_tready;
        if (hs_s) begin
            fetch_addr_s = rd_ptr_r + PTR_ONE;
        end else begin
            fetch_addr_s = rd_ptr_r;
        end
        rd_ptr_n = fetch_addr_s;
        load_s   = (!tvalid_r || m_axis_tready) && (fetch_addr_s != commit_ptr_r);
        if (load_s) begin
            tvalid_n = 1'b1;
        end else if (hs_s) begin
            tvalid_n = 1'b0;
        end else begin
            tvalid_n = tvalid_r;
        end
        empty_n = (rd_ptr_n == commit_ptr_n) && !tvalid_n;
    end

    // Frame RAM write port; contents need no reset.
    always_ff @(posedge clk_int) begin
        if (ram_we_s) begin
            mem[wr_ptr_r] <= {rx_axis_tlast, rx_axis_tdata};
        end
    end

    // State, pointers, output register and statistics.
    always_ff @(posedge clk_int or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_r       <= ST_IDLE;
            wr_ptr_r      <= {ADDR_WIDTH{1'b0}};
            commit_ptr_r  <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r      <= {ADDR_WIDTH{1'b0}};
            byte_cnt_r    <= 16'd0;
            match_uc_r    <= 1'b0;
            match_bc_r    <= 1'b0;
            frames_ok_r   <= {CNT_WIDTH{1'b0}};
            frames_drop_r <= {CNT_WIDTH{1'b0}};
            overflow_r    <= 1'b0;
            tvalid_r      <= 1'b0;
            tlast_r       <= 1'b0;
            tdata_r       <= 8'h00;
            empty_r       <= 1'b1;
        end else begin
            state_r      <= state_n;
            wr_ptr_r     <= wr_ptr_n;
            commit_ptr_r <= commit_ptr_n;
            rd_ptr_r     <= rd_ptr_n;
            byte_cnt_r   <= byte_cnt_n;
            match_uc_r   <= match_uc_n;
            match_bc_r   <= match_bc_n;
            overflow_r   <= ovf_s;
            tvalid_r     <= tvalid_n;
            empty_r      <= empty_n;
            if (ok_inc_s) begin
                frames_ok_r <= sat_inc(frames_ok_r);
            end
            if (drop_inc_s) begin
                frames_drop_r <= sat_inc(frames_drop_r);
            end
            if (load_s) begin
                {tlast_r, tdata_r} <= mem[fetch_addr_s];
            end
        end
    end

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;
    assign frames_ok     = frames_ok_r;
    assign frames_drop   = frames_drop_r;
    assign overflow      = overflow_r;
    assign buffer_empty  = empty_r;

endmodule

// File: tb/tb_rgmii_rx_frame_buffer.sv
// Bench for rgmii_rx_frame_buffer: directed and random frames checked against a frame-level
// model (accept rule + expected byte queue + counters).
module tb_rgmii_rx_frame_buffer;

    localparam int          AW      = 7;
    localparam int          CAP     = (1 << AW) - 1;
    localparam int          MIN_LEN = 14;
    localparam logic [47:0] MAC     = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] OTHER   = 48'h02_00_00_00_00_02;

    logic        clk_int = 1'b0;
    logic        rst_int_n;
    logic [7:0]  rx_axis_tdata;
    logic        rx_axis_tvalid;
    logic        rx_axis_tlast;
    logic        rx_axis_tuser;
    logic [47:0] mac_addr;
    logic        promisc;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [15:0] frames_ok;
    logic [15:0] frames_drop;
    logic        overflow;
    logic        buffer_empty;

    int          checks   = 0;
    int          failures = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  frm[$];
    int          exp_ok   = 0;
    int          exp_drop = 0;
    int          ovf_pulses = 0;
    int          tready_mode = 1;

    always #5 clk_int = ~clk_int;

    rgmii_rx_frame_buffer #(.ADDR_WIDTH(AW), .MIN_LEN(MIN_LEN), .CNT_WIDTH(16)) dut (
        .clk_int        (clk_int),
        .rst_int_n      (rst_int_n),
        .rx_axis_tdata  (rx_axis_tdata),
        .rx_axis_tvalid (rx_axis_tvalid),
        .rx_axis_tlast  (rx_axis_tlast),
        .rx_axis_tuser  (rx_axis_tuser),
        .mac_addr       (mac_addr),
        .promisc        (promisc),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .frames_ok      (frames_ok),
        .frames_drop    (frames_drop),
        .overflow       (overflow),
        .buffer_empty   (buffer_empty)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit accept_range(input int lo, input int hi, input logic tu, input logic prom);
        logic [47:0] da;
        if (hi - lo < MIN_LEN) return 1'b0;
        da = {frm[lo], frm[lo+1], frm[lo+2], frm[lo+3], frm[lo+4], frm[lo+5]};
        return !tu && (prom || da == MAC || da == BCAST);
    endfunction

    task automatic model_range(input int lo, input int hi, input bit acc);
        if (acc) begin
            for (int i = lo; i < hi; i++) exp_q.push_back({(i == hi - 1), frm[i]});
            exp_ok++;
        end else begin
            exp_drop++;
        end
    endtask

    task automatic build_frame(input logic [47:0] da, input int len);
        frm.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 6) frm.push_back(da[8*(5-i) +: 8]);
            else       frm.push_back(8'($urandom));
        end
    endtask

    // tlast marks the final byte of frm; tuser is noise except on that beat.
    task automatic send_range(input int lo, input int hi, input logic tu);
        for (int i = lo; i < hi; i++) begin
            rx_axis_tdata  = frm[i];
            rx_axis_tvalid = 1'b1;
            rx_axis_tlast  = (i == frm.size() - 1);
            rx_axis_tuser  = (i == frm.size() - 1) ? tu : 1'($urandom_range(0, 1));
            @(posedge clk_int); #1;
        end
        rx_axis_tvalid = 1'b0;
        rx_axis_tlast  = 1'b0;
        rx_axis_tuser  = 1'b0;
    endtask

    task automatic frame(input logic [47:0] da, input int len, input logic tu);
        build_frame(da, len);
        send_range(0, len, tu);
        model_range(0, len, accept_range(0, len, tu, promisc));
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (!(buffer_empty && exp_q.size() == 0) && n < budget) begin
            @(posedge clk_int); #1;
            n++;
        end
        chk("drain_within_budget", 64'(n < budget), 64'd1);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_frames_ok"}, 64'(frames_ok), 64'(exp_ok));
        chk({tag, "_frames_drop"}, 64'(frames_drop), 64'(exp_drop));
    endtask

    // Consumer ready pattern; random mode keeps ready high at least 3 of every 4 cycles.
    initial begin
        int cyc;
        cyc = 0;
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk_int); #1;
            cyc++;
            case (tready_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = (cyc % 4 == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            endcase
        end
    end

    // Output monitor: every handshake byte against the model queue, plus stall stability.
    initial begin
        logic [8:0] prev;
        bit         stall;
        stall = 1'b0;
        prev  = 9'h000;
        forever begin
            @(negedge clk_int);
            if (!rst_int_n) begin
                stall = 1'b0;
            end else begin
                if (overflow) ovf_pulses++;
                if (stall) begin
                    chk("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
                    chk("hold_data", 64'({m_axis_tlast, m_axis_tdata}), 64'(prev));
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
                    else chk("out_byte", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q.pop_front()));
                end
                stall = m_axis_tvalid && !m_axis_tready;
                prev  = {m_axis_tlast, m_axis_tdata};
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int ovf0;
        logic [47:0] da;
        rst_int_n      = 1'b0;
        rx_axis_tdata  = 8'h00;
        rx_axis_tvalid = 1'b0;
        rx_axis_tlast  = 1'b0;
        rx_axis_tuser  = 1'b0;
        mac_addr       = MAC;
        promisc        = 1'b0;
        repeat (3) @(posedge clk_int);
        #1;
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_empty", 64'(buffer_empty), 64'd1);
        chk_counters("rst");
        rst_int_n = 1'b1;
        repeat (2) @(posedge clk_int);
        #1;

        // Unicast 64-byte frame, first output exactly two cycles after tlast.
        frame(MAC, 64, 1'b0);
        chk("latency_t1_idle", 64'(m_axis_tvalid), 64'd0);
        @(posedge clk_int); #1;
        chk("latency_t2_valid", 64'(m_axis_tvalid), 64'd1);
        chk("latency_t2_data", 64'(m_axis_tdata), 64'h02);
        wait_empty(500);
        chk_counters("unicast");

        // Address filter with and without promiscuous mode, back to back.
        frame(BCAST, 64, 1'b0);
        frame(OTHER, 64, 1'b0);
        promisc = 1'b1;
        frame(BCAST, 64, 1'b0);
        frame(OTHER, 64, 1'b0);
        promisc = 1'b0;
        wait_empty(1000);
        chk_counters("filter");

        // Runt boundary.
        frame(MAC, MIN_LEN - 1, 1'b0);
        frame(MAC, MIN_LEN, 1'b0);
        wait_empty(500);
        chk_counters("runt");

        // MAC error then short frame: nothing out; a later frame proves the rewind.
        frame(MAC, 60, 1'b1);
        frame(MAC, 10, 1'b0);
        repeat (4) @(posedge clk_int);
        #1;
        chk("err_empty", 64'(buffer_empty), 64'd1);
        chk_counters("err");
        frame(MAC, 20, 1'b0);
        wait_empty(500);

        // Overflow: 64 committed bytes held, then 80 more cannot fit in CAP.
        tready_mode = 0;
        repeat (3) @(posedge clk_int);
        #1;
        ovf0 = ovf_pulses;
        frame(MAC, 64, 1'b0);
        build_frame(MAC, 80);
        send_range(0, 80, 1'b0);
        model_range(0, 80, accept_range(0, 80, 1'b0, promisc) && (64 + 80 <= CAP));
        repeat (3) @(posedge clk_int);
        #1;
        chk("ovf_pulse_count", 64'(ovf_pulses - ovf0), 64'd1);
        chk("ovf_not_empty", 64'(buffer_empty), 64'd0);
        chk_counters("ovf");
        tready_mode = 1;
        wait_empty(500);

        // Three back-to-back frames across the RAM wrap with random ready.
        tready_mode = 2;
        frame(MAC, 64, 1'b0);
        frame(BCAST, 64, 1'b0);
        frame(MAC, 64, 1'b0);
        wait_empty(2000);
        chk_counters("wrap");

        // Random frames, drained between each so space is never the limit.
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 2))
                0:       da = MAC;
                1:       da = BCAST;
                default: da = {8'($urandom), 8'($urandom), 32'($urandom)};
            endcase
            promisc = 1'($urandom_range(0, 3) == 0);
            frame(da, $urandom_range(1, 100), 1'($urandom_range(0, 3) == 0));
            wait_empty(1000);
        end
        promisc = 1'b0;
        chk_counters("random");

        // Reset mid-frame with a held output byte; the tail must be filtered out.
        tready_mode = 0;
        frame(MAC, 64, 1'b0);
        build_frame(MAC, 50);
        frm[30] = 8'h55;
        send_range(0, 30, 1'b0);
        rst_int_n = 1'b0;
        #2;
        exp_q.delete();
        exp_ok   = 0;
        exp_drop = 0;
        chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("mid_rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("mid_rst_overflow", 64'(overflow), 64'd0);
        chk("mid_rst_empty", 64'(buffer_empty), 64'd1);
        chk_counters("mid_rst");
        @(posedge clk_int); #1;
        rst_int_n   = 1'b1;
        tready_mode = 1;
        send_range(30, 50, 1'b0);
        model_range(30, 50, accept_range(30, 50, 1'b0, promisc));
        frame(MAC, 64, 1'b0);
        wait_empty(500);
        chk_counters("post_rst");

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
